// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan driver: glyph patterns, segment bit positions, index sizing.
// Latency: n/a (package only).
// Backpressure: n/a.
package seg_pkg;

    // Active-high glyph patterns, bit0=a ... bit6=g, bit7 (dp) clear
    localparam logic [7:0] SEG_0   = 8'h3F;
    localparam logic [7:0] SEG_1   = 8'h06;
    localparam logic [7:0] SEG_2   = 8'h5B;
    localparam logic [7:0] SEG_3   = 8'h4F;
    localparam logic [7:0] SEG_4   = 8'h66;
    localparam logic [7:0] SEG_5   = 8'h6D;
    localparam logic [7:0] SEG_6   = 8'h7D;
    localparam logic [7:0] SEG_7   = 8'h07;
    localparam logic [7:0] SEG_8   = 8'h7F;
    localparam logic [7:0] SEG_9   = 8'h6F;
    localparam logic [7:0] SEG_A_G = 8'h77;
    localparam logic [7:0] SEG_B_G = 8'h7C;
    localparam logic [7:0] SEG_C_G = 8'h39;
    localparam logic [7:0] SEG_D_G = 8'h5E;
    localparam logic [7:0] SEG_E_G = 8'h79;
    localparam logic [7:0] SEG_F_G = 8'h71;
    localparam logic [7:0] SEG_OFF = 8'h00;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hex7_decode.sv
// Nibble to active-high seven-segment pattern with decimal point and blanking.
// Latency: combinational.
// Backpressure: none.
module hex7_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] pattern
);

    logic [7:0] glyph;

    always_comb begin
        glyph = SEG_OFF;
        case (nibble)
            4'h0: glyph = SEG_0;
            4'h1: glyph = SEG_1;
            4'h2: glyph = SEG_2;
            4'h3: glyph = SEG_3;
            4'h4: glyph = SEG_4;
            4'h5: glyph = SEG_5;
            4'h6: glyph = SEG_6;
            4'h7: glyph = SEG_7;
            4'h8: glyph = SEG_8;
            4'h9: glyph = SEG_9;
            4'hA: glyph = SEG_A_G;
            4'hB: glyph = SEG_B_G;
            4'hC: glyph = SEG_C_G;
            4'hD: glyph = SEG_D_G;
            4'hE: glyph = SEG_E_G;
            4'hF: glyph = SEG_F_G;
        endcase

        pattern         = glyph;
        pattern[SEG_DP] = dp;
        // A dark digit drops the decimal point too
        if (blank) begin
            pattern = SEG_OFF;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment driver with double-buffered display word, LZ suppression and dead time.
// Latency: an/seg registered, one cycle behind scan state; update lands in shadow at the next frame wrap.
// Backpressure: none; free-running scan, update is a fire-and-forget strobe (last one per frame wins).
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int SCAN_DIV       = 100000,
    parameter int BLANK_CYCLES   = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [4*NUM_DIGITS-1:0]             data,
    input  logic [NUM_DIGITS-1:0]               dp_en,
    input  logic [NUM_DIGITS-1:0]               blank_en,
    input  logic                                lz_suppress,
    input  logic                                update,
    output logic [NUM_DIGITS-1:0]               an,
    output logic [7:0]                          seg,
    output logic [idx_width(NUM_DIGITS)-1:0]    digit_idx,
    output logic                                frame_done
);

    localparam int IDX_W = idx_width(NUM_DIGITS);
    localparam int PW    = $clog2(SCAN_DIV);

    localparam logic [PW-1:0]         PRE_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0]         PRE_BLANK = PW'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [7:0]            SEG_IDLE  = {8{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_IDLE   = {NUM_DIGITS{AN_ACTIVE_LOW}};

    logic [PW-1:0]           prescaler;
    logic [4*NUM_DIGITS-1:0] stage_data,  shadow_data;
    logic [NUM_DIGITS-1:0]   stage_dp,    shadow_dp;
    logic [NUM_DIGITS-1:0]   stage_blank, shadow_blank;
    logic                    pending;

    logic                    pre_wrap;
    logic                    frame_wrap;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blank;
    logic                    lz_run;
    logic                    lz_dark;
    logic [NUM_DIGITS-1:0]   an_onehot;
    logic [7:0]              pattern;

    assign pre_wrap   = (prescaler == PRE_LAST);
    assign frame_wrap = pre_wrap && (digit_idx == IDX_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler  <= '0;
            digit_idx  <= '0;
            frame_done <= 1'b0;
        end else begin
            prescaler  <= pre_wrap ? '0 : prescaler + 1'b1;
            frame_done <= frame_wrap;
            if (pre_wrap) begin
                digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
            end
        end
    end

    // Shadow samples the old staging on the wrap edge, so a coincident update waits one frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_data   <= '0;
            stage_dp     <= '0;
            stage_blank  <= '0;
            shadow_data  <= '0;
            shadow_dp    <= '0;
            shadow_blank <= '0;
            pending      <= 1'b0;
        end else begin
            if (frame_wrap && pending) begin
                shadow_data  <= stage_data;
                shadow_dp    <= stage_dp;
                shadow_blank <= stage_blank;
            end
            if (update) begin
                stage_data  <= data;
                stage_dp    <= dp_en;
                stage_blank <= blank_en;
                pending     <= 1'b1;
            end else if (frame_wrap) begin
                pending     <= 1'b0;
            end
        end
    end

    // Walk from the leftmost digit so lz_run means "this digit and all above are zero"
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        an_onehot = '0;
        lz_run    = 1'b1;
        lz_dark   = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz_run = lz_run && (shadow_data[4*i +: 4] == 4'h0);
            if (digit_idx == IDX_W'(i)) begin
                cur_nib      = shadow_data[4*i +: 4];
                cur_dp       = shadow_dp[i];
                cur_blank    = shadow_blank[i];
                an_onehot[i] = 1'b1;
                lz_dark      = lz_run && (i != 0);
            end
        end
    end

    hex7_decode u_decode (
        .nibble  (cur_nib),
        .dp      (cur_dp),
        .blank   (cur_blank || (lz_suppress && lz_dark)),
        .pattern (pattern)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= AN_IDLE;
            seg <= SEG_IDLE;
        end else if (prescaler < PRE_BLANK) begin
            an  <= AN_IDLE;
            seg <= SEG_IDLE;
        end else begin
            an  <= an_onehot ^ AN_IDLE;
            seg <= pattern ^ SEG_IDLE;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with 4 digits, 8-cycle digit periods, 2 dead cycles, active-low pins.
// Latency: n/a.
// Backpressure: n/a.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data;
    logic [3:0]  dp_en;
    logic [3:0]  blank_en;
    logic        lz_suppress;
    logic        update;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic        lz;
        logic [31:0] segs;   // expected seg pins {digit3, digit2, digit1, digit0}
    } vec_t;

    vec_t tbl [7];

    seg_scan_driver #(
        .NUM_DIGITS     (4),
        .SCAN_DIV       (8),
        .BLANK_CYCLES   (2),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data        (data),
        .dp_en       (dp_en),
        .blank_en    (blank_en),
        .lz_suppress (lz_suppress),
        .update      (update),
        .an          (an),
        .seg         (seg),
        .digit_idx   (digit_idx),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_frame(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (frame_done) break;
        end
        chk("frame_wait", {31'd0, frame_done}, 32'd1);
    endtask

    task automatic pulse_update;
        update = 1'b1;
        tick();
        update = 1'b0;
    endtask

    // Entered on the frame_done cycle; leaves on the next frame_done cycle
    task automatic check_frame(input string name, input logic [31:0] segs);
        bit fd_bad = 1'b0;
        for (int c = 1; c < 32; c++) begin
            int d;
            int ph;
            tick();
            if (frame_done) fd_bad = 1'b1;
            d  = (c - 1) / 8;
            ph = (c - 1) % 8;
            if (ph == 0) begin
                chk({name, "_dead"}, {20'd0, an, seg}, {20'd0, 4'hF, 8'hFF});
            end
            if (ph == 4) begin
                chk({name, "_digit"}, {18'd0, an, seg, digit_idx},
                    {18'd0, 4'hF ^ (4'b0001 << d), segs[8*d +: 8], 2'(d)});
            end
        end
        tick();
        chk({name, "_wrap"}, {29'd0, frame_done, digit_idx, fd_bad}, {29'd0, 1'b1, 2'd0, 1'b0});
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int n;
        data        = v.data;
        dp_en       = v.dp;
        blank_en    = v.blank;
        lz_suppress = v.lz;
        pulse_update();
        wait_frame(n);
        chk({name, "_latency"}, n, 31);
        check_frame(name, v.segs);
    endtask

    initial begin
        int n;
        tbl[0] = '{16'h12AF, 4'b0000, 4'b0000, 1'b0, {8'hF9, 8'hA4, 8'h88, 8'h8E}};
        tbl[1] = '{16'h0040, 4'b0000, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'h99, 8'hC0}};
        tbl[2] = '{16'h0000, 4'b0000, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
        tbl[3] = '{16'h8888, 4'b0001, 4'b0010, 1'b0, {8'h80, 8'h80, 8'hFF, 8'h00}};
        tbl[4] = '{16'h3C5E, 4'b1000, 4'b0000, 1'b0, {8'h30, 8'hC6, 8'h92, 8'h86}};
        tbl[5] = '{16'h0009, 4'b0100, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'h90}};
        tbl[6] = '{16'h0D07, 4'b0000, 4'b0000, 1'b1, {8'hFF, 8'hA1, 8'hC0, 8'hF8}};

        rst         = 1'b1;
        data        = '0;
        dp_en       = '0;
        blank_en    = '0;
        lz_suppress = 1'b0;
        update      = 1'b0;
        tick();
        tick();
        chk("reset_state", {17'd0, an, seg, digit_idx, frame_done}, {17'd0, 4'hF, 8'hFF, 2'd0, 1'b0});
        rst = 1'b0;

        wait_frame(n);
        chk("first_frame_len", n, 32);

        for (int i = 0; i < 7; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Tear-free: new word written mid-frame must not touch digits 2 and 3 of this frame
        run_vec(tbl[0], "reload");
        lz_suppress = 1'b0;
        for (int i = 0; i < 19; i++) tick();
        data = 16'h0000;
        pulse_update();
        tick();
        tick();
        chk("tear_digit2_old", {20'd0, an, seg}, {20'd0, 4'hB, 8'hA4});
        for (int i = 0; i < 8; i++) tick();
        chk("tear_digit3_old", {20'd0, an, seg}, {20'd0, 4'h7, 8'hF9});
        wait_frame(n);
        chk("tear_wrap_dist", n, 2);
        check_frame("tear_new", {8'hC0, 8'hC0, 8'hC0, 8'hC0});

        // Update on the wrap cycle: shadow takes the prior staging first
        data = 16'h1111;
        pulse_update();
        for (int i = 0; i < 30; i++) tick();
        data = 16'h5555;
        pulse_update();
        chk("coinc_wrap", {31'd0, frame_done}, 32'd1);
        check_frame("coinc_prior", {8'hF9, 8'hF9, 8'hF9, 8'hF9});
        check_frame("coinc_new", {8'h92, 8'h92, 8'h92, 8'h92});

        // Mid-scan reset with an update still pending
        data = 16'h7777;
        pulse_update();
        for (int i = 0; i < 12; i++) tick();
        rst = 1'b1;
        #1;
        chk("midscan_rst", {17'd0, an, seg, digit_idx, frame_done}, {17'd0, 4'hF, 8'hFF, 2'd0, 1'b0});
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst", {17'd0, an, seg, digit_idx, frame_done}, {17'd0, 4'hF, 8'hFF, 2'd0, 1'b0});
        wait_frame(n);
        chk("post_rst_frame_len", n, 31);
        check_frame("post_rst_shadow", {8'hC0, 8'hC0, 8'hC0, 8'hC0});

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
